// File: rtl/datamem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package datamem_arb_pkg;

    localparam int DEF_NUM_ACCEL    = 2;
    localparam int DEF_ADDR_W       = 16;
    localparam int DEF_WORD_W       = 32;
    localparam int DEF_LINE_W       = 512;
    localparam int DEF_STARVE_LIMIT = 8;

    // Accelerator index field in the response record; wide enough for any sane port count.
    localparam int ACC_IDX_W = 8;

    typedef enum logic {
        OWN_CPU   = 1'b0,
        OWN_ACCEL = 1'b1
    } owner_e;

    // Pending read return: who issued the read granted last cycle.
    typedef struct packed {
        logic                 valid;
        owner_e               kind;
        logic [ACC_IDX_W-1:0] idx;
    } resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping at N.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk the ports starting at ptr; the first live request wins.
    always_comb begin : pick
        int          c;
        logic [IW-1:0] ci;
        c   = 0;
        ci  = '0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr) + k;
            if (c >= N) c = c - N;
            ci = IW'(c);
            if (!any && req[ci]) begin
                any     = 1'b1;
                gnt[ci] = 1'b1;
                idx     = ci;
            end
        end
    end

endmodule

// File: rtl/datamem_arbiter.sv
// One-access-per-cycle arbiter between the CPU port and NUM_ACCEL accelerators
// in front of the shared data memory. CPU has priority, limited by a starvation
// guard; accelerators share leftover slots round-robin. Reads return one cycle
// later, steered back to whoever issued them.
module datamem_arbiter
    import datamem_arb_pkg::*;
#(
    parameter int NUM_ACCEL    = DEF_NUM_ACCEL,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int WORD_W       = DEF_WORD_W,
    parameter int LINE_W       = DEF_LINE_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                                 clk,
    input  logic                                 rst,
    // CPU port
    input  logic                                 cpu_req,
    input  logic                                 cpu_wrt_en,
    input  logic [ADDR_W-1:0]                    cpu_addr,
    input  logic [WORD_W-1:0]                    cpu_wrt_data,
    output logic                                 cpu_stall,
    output logic                                 cpu_rd_valid,
    output logic [WORD_W-1:0]                    cpu_rd_data,
    // accelerator ports
    input  logic [NUM_ACCEL-1:0]                 accel_req,
    input  logic [NUM_ACCEL-1:0]                 accel_wrt_en,
    input  logic [NUM_ACCEL-1:0][ADDR_W-1:0]     accel_addr,
    input  logic [NUM_ACCEL-1:0][WORD_W-1:0]     accel_wrt_data,
    output logic [NUM_ACCEL-1:0]                 accel_gnt,
    output logic [NUM_ACCEL-1:0]                 accel_rd_valid,
    output logic [LINE_W-1:0]                    accel_rd_data,
    // memory side
    output logic [ADDR_W-1:0]                    mem_addr,
    output logic [WORD_W-1:0]                    mem_wrt_data,
    output logic                                 mem_wrt_en,
    input  logic [LINE_W-1:0]                    mem_rd_data
);

    localparam int IW    = (NUM_ACCEL > 1) ? $clog2(NUM_ACCEL) : 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]     starve_cnt;
    logic [IW-1:0]        rr_ptr;
    resp_t                resp;
    resp_t                resp_nxt;

    logic [NUM_ACCEL-1:0] rr_gnt;
    logic [IW-1:0]        rr_idx;
    logic                 any_accel;
    logic                 cpu_win;
    logic                 accel_win;
    logic                 starved;

    rr_arbiter #(.N(NUM_ACCEL), .IW(IW)) u_rr (
        .req (accel_req),
        .ptr (rr_ptr),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (any_accel)
    );

    // Zero-cycle arbitration: CPU first unless it has hogged STARVE_LIMIT slots.
    always_comb begin
        starved   = (starve_cnt >= CNT_W'(STARVE_LIMIT));
        cpu_win   = cpu_req && (!starved || !any_accel);
        accel_win = !cpu_win && any_accel;
        accel_gnt = accel_win ? rr_gnt : '0;
        cpu_stall = cpu_req && !cpu_win;
    end

    // Memory drive from the winner; write strobe forced low with no winner.
    always_comb begin
        mem_addr     = cpu_addr;
        mem_wrt_data = cpu_wrt_data;
        mem_wrt_en   = 1'b0;
        if (cpu_win) begin
            mem_wrt_en = cpu_wrt_en;
        end else if (accel_win) begin
            mem_addr     = accel_addr[rr_idx];
            mem_wrt_data = accel_wrt_data[rr_idx];
            mem_wrt_en   = accel_wrt_en[rr_idx];
        end
    end

    // Next response record: only a granted read leaves something to return.
    always_comb begin
        resp_nxt       = '0;
        resp_nxt.kind  = OWN_CPU;
        if (cpu_win && !cpu_wrt_en) begin
            resp_nxt.valid = 1'b1;
            resp_nxt.kind  = OWN_CPU;
        end else if (accel_win && !accel_wrt_en[rr_idx]) begin
            resp_nxt.valid = 1'b1;
            resp_nxt.kind  = OWN_ACCEL;
            resp_nxt.idx   = ACC_IDX_W'(rr_idx);
        end
    end

    // Starvation counter: counts CPU wins over a pending accelerator, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (accel_win || !any_accel) begin
            starve_cnt <= '0;
        end else if (cpu_win && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Round-robin pointer moves just past the accelerator that was served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accel_win) begin
            if (rr_idx == IW'(NUM_ACCEL - 1)) rr_ptr <= '0;
            else                              rr_ptr <= rr_idx + 1'b1;
        end
    end

    // One-deep return pipeline; reset kills any in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp <= '0;
        end else begin
            resp <= resp_nxt;
        end
    end

    // Steer the returning line to its owner; data paths are unqualified.
    always_comb begin
        cpu_rd_valid   = resp.valid && (resp.kind == OWN_CPU);
        cpu_rd_data    = mem_rd_data[WORD_W-1:0];
        accel_rd_data  = mem_rd_data;
        accel_rd_valid = '0;
        for (int i = 0; i < NUM_ACCEL; i++) begin
            accel_rd_valid[i] = resp.valid && (resp.kind == OWN_ACCEL) &&
                                (resp.idx == ACC_IDX_W'(i));
        end
    end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: directed scenarios plus randomized traffic,
// all checked against a cycle-level reference model of the arbitration rules.
module tb_datamem_arbiter;

    localparam int NA = 2;
    localparam int AW = 16;
    localparam int WW = 32;
    localparam int LW = 512;
    localparam int SL = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cpu_req, cpu_wrt_en;
    logic [AW-1:0]          cpu_addr;
    logic [WW-1:0]          cpu_wrt_data;
    logic                   cpu_stall, cpu_rd_valid;
    logic [WW-1:0]          cpu_rd_data;
    logic [NA-1:0]          accel_req, accel_wrt_en;
    logic [NA-1:0][AW-1:0]  accel_addr;
    logic [NA-1:0][WW-1:0]  accel_wrt_data;
    logic [NA-1:0]          accel_gnt, accel_rd_valid;
    logic [LW-1:0]          accel_rd_data;
    logic [AW-1:0]          mem_addr;
    logic [WW-1:0]          mem_wrt_data;
    logic                   mem_wrt_en;
    logic [LW-1:0]          mem_rd_data;

    always #5 clk = ~clk;

    datamem_arbiter #(
        .NUM_ACCEL(NA), .ADDR_W(AW), .WORD_W(WW), .LINE_W(LW), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wrt_en(cpu_wrt_en), .cpu_addr(cpu_addr),
        .cpu_wrt_data(cpu_wrt_data), .cpu_stall(cpu_stall),
        .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
        .accel_req(accel_req), .accel_wrt_en(accel_wrt_en), .accel_addr(accel_addr),
        .accel_wrt_data(accel_wrt_data), .accel_gnt(accel_gnt),
        .accel_rd_valid(accel_rd_valid), .accel_rd_data(accel_rd_data),
        .mem_addr(mem_addr), .mem_wrt_data(mem_wrt_data), .mem_wrt_en(mem_wrt_en),
        .mem_rd_data(mem_rd_data)
    );

    int total = 0;
    int bad   = 0;

    // reference model state: -1 = CPU, 0.. = accel index, -2 = nobody
    int m_starve, m_ptr, m_win;
    int m_pend[$];

    // last-cycle observations for directed checks
    logic          obs_cpu_rdv, obs_stall, obs_wen;
    logic [NA-1:0] obs_acc_rdv, obs_gnt;
    logic [AW-1:0] obs_addr;
    logic [WW-1:0] obs_wdata;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic rand_line();
        for (int w = 0; w < LW/32; w++) mem_rd_data[w*32 +: 32] = $urandom();
    endtask

    task automatic model_reset();
        m_starve = 0;
        m_ptr    = 0;
        m_pend.delete();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: caller has set inputs just after a falling edge.
    task automatic step();
        int            j, exp_owner;
        logic [NA-1:0] eg, er;
        logic          ew;
        rand_line();
        m_win = -2;
        if (cpu_req && (m_starve < SL || accel_req == '0)) m_win = -1;
        else if (accel_req != '0) begin
            for (int k = 0; k < NA; k++) begin
                j = (m_ptr + k) % NA;
                if (m_win == -2 && accel_req[j]) m_win = j;
            end
        end
        #1;
        eg = '0;
        if (m_win >= 0) eg[m_win] = 1'b1;
        ew = (m_win == -1) ? cpu_wrt_en : (m_win >= 0) ? accel_wrt_en[m_win] : 1'b0;
        chk("gnt", accel_gnt, eg);
        chk("stall", cpu_stall, cpu_req && (m_win != -1));
        chk("wen", mem_wrt_en, ew);
        if (m_win == -1) begin
            chk("addr_cpu", mem_addr, cpu_addr);
            chk("wdata_cpu", mem_wrt_data, cpu_wrt_data);
        end else if (m_win >= 0) begin
            chk("addr_acc", mem_addr, accel_addr[m_win]);
            chk("wdata_acc", mem_wrt_data, accel_wrt_data[m_win]);
        end
        exp_owner = -2;
        if (m_pend.size() > 0) exp_owner = m_pend.pop_front();
        er = '0;
        if (exp_owner >= 0) er[exp_owner] = 1'b1;
        chk("cpu_rdv", cpu_rd_valid, exp_owner == -1);
        chk("acc_rdv", accel_rd_valid, er);
        if (exp_owner == -1) chk("cpu_rdd", cpu_rd_data, mem_rd_data[WW-1:0]);
        chk("acc_rdd", accel_rd_data, mem_rd_data);
        obs_cpu_rdv = cpu_rd_valid;  obs_acc_rdv = accel_rd_valid;
        obs_gnt     = accel_gnt;     obs_stall   = cpu_stall;
        obs_wen     = mem_wrt_en;    obs_addr    = mem_addr;
        obs_wdata   = mem_wrt_data;
        @(posedge clk);
        if (m_win == -1 && !cpu_wrt_en) m_pend.push_back(-1);
        if (m_win >= 0 && !accel_wrt_en[m_win]) m_pend.push_back(m_win);
        if (m_win >= 0) begin
            m_starve = 0;
            m_ptr    = (m_win + 1) % NA;
        end else if (accel_req == '0) m_starve = 0;
        else if (m_starve < SL) m_starve++;
        #1;
        chk("starve_cnt", dut.starve_cnt, m_starve);
        chk("rr_ptr", dut.rr_ptr, m_ptr);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_wrt_en = 1'b0; cpu_addr = '0; cpu_wrt_data = '0;
        accel_req = '0; accel_wrt_en = '0; accel_addr = '0; accel_wrt_data = '0;
    endtask

    initial begin
        int cpu_pct;
        rst = 1'b1;
        idle_inputs();
        mem_rd_data = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        // reset state with nothing requested
        chk("rst_cpu_rdv", cpu_rd_valid, 1'b0);
        chk("rst_acc_rdv", accel_rd_valid, '0);
        chk("rst_stall", cpu_stall, 1'b0);
        chk("rst_gnt", accel_gnt, '0);
        chk("rst_wen", mem_wrt_en, 1'b0);
        chk("rst_starve", dut.starve_cnt, 0);
        chk("rst_ptr", dut.rr_ptr, 0);
        rst = 1'b0;

        // CPU read @0x0040
        cpu_req = 1'b1; cpu_addr = 16'h0040;
        step();
        chk("cpu_rd_addr", obs_addr, 16'h0040);
        cpu_req = 1'b0;
        step();
        chk("cpu_rd_ret", obs_cpu_rdv, 1'b1);

        // two accelerators reading continuously alternate
        accel_req = 2'b11; accel_addr[0] = 16'h1000; accel_addr[1] = 16'h2000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_alt", obs_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        accel_req = '0;
        step();

        // CPU hammering while accel1 waits: 8 CPU wins then accel1
        cpu_req = 1'b1; cpu_addr = 16'h0100; accel_req = 2'b10;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("starve_gnt", obs_gnt, (i == 8) ? 2'b10 : 2'b00);
            chk("starve_stall", obs_stall, i == 8);
        end
        idle_inputs();
        step();

        // CPU write, no return
        cpu_req = 1'b1; cpu_wrt_en = 1'b1; cpu_addr = 16'h0010; cpu_wrt_data = 32'hDEADBEEF;
        step();
        chk("wr_en", obs_wen, 1'b1);
        chk("wr_addr", obs_addr, 16'h0010);
        chk("wr_data", obs_wdata, 32'hDEADBEEF);
        idle_inputs();
        step();
        chk("wr_no_cpu_ret", obs_cpu_rdv, 1'b0);
        chk("wr_no_acc_ret", obs_acc_rdv, 2'b00);

        // interleaved returns in issue order
        cpu_req = 1'b1; cpu_addr = 16'h0200;
        step();
        cpu_req = 1'b0; accel_req = 2'b10; accel_addr[1] = 16'h0300;
        step();
        chk("il_cpu_ret", obs_cpu_rdv, 1'b1);
        accel_req = '0;
        step();
        chk("il_acc_ret", obs_acc_rdv, 2'b10);

        // reset with a read in flight and nonzero state
        accel_req = 2'b01;
        step();
        accel_req = 2'b10; cpu_req = 1'b1;
        step();
        idle_inputs();
        reset_pulse();
        chk("rst_mid_starve", dut.starve_cnt, 0);
        chk("rst_mid_ptr", dut.rr_ptr, 0);
        step();
        chk("rst_mid_no_ret", obs_cpu_rdv, 1'b0);

        // randomized traffic with withdrawals and occasional resets
        for (int i = 0; i < 3000; i++) begin
            cpu_pct      = ((i / 200) % 2 == 1) ? 95 : 50;
            cpu_req      = ($urandom_range(0, 99) < cpu_pct);
            cpu_wrt_en   = ($urandom_range(0, 2) == 0);
            cpu_addr     = AW'($urandom());
            cpu_wrt_data = $urandom();
            for (int j = 0; j < NA; j++) begin
                if (!accel_req[j]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        accel_req[j]      = 1'b1;
                        accel_wrt_en[j]   = ($urandom_range(0, 2) == 0);
                        accel_addr[j]     = AW'($urandom());
                        accel_wrt_data[j] = $urandom();
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    accel_req[j] = 1'b0;
                end
            end
            if ($urandom_range(0, 499) == 0) reset_pulse();
            step();
            for (int j = 0; j < NA; j++) if (m_win == j) accel_req[j] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/datamem_arbiter.md
# datamem_arbiter

Sequencing arbiter in front of the shared CPU data memory. It grants one access per cycle between the CPU load/store port and NUM_ACCEL accelerator request ports. The CPU has priority, bounded by a starvation guard. Accelerators share the remaining slots round-robin. Read data returns one cycle later, tagged back to the requester that issued the read.

## Interface
- NUM_ACCEL, 2, number of accelerator request ports (≥1)
- ADDR_W, 16, memory address width
- WORD_W, 32, write-data and CPU read-data width
- LINE_W, 512, memory read-line width
- STARVE_LIMIT, 8, maximum consecutive CPU wins while any accelerator is pending
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req / cpu_wrt_en  in  1 / 1  CPU access request; 1 = write, 0 = read
- cpu_addr / cpu_wrt_data  in  ADDR_W / WORD_W  CPU address and store data
- cpu_stall  out  1  CPU request present but not granted this cycle
- cpu_rd_valid / cpu_rd_data  out  1 / WORD_W  CPU read return; data = mem_rd_data[WORD_W-1:0]
- accel_req / accel_wrt_en  in  NUM_ACCEL each  per-port request and write flag
- accel_addr / accel_wrt_data  in  NUM_ACCEL×ADDR_W / NUM_ACCEL×WORD_W  per-port address and data
- accel_gnt  out  NUM_ACCEL  one-hot grant, same cycle as the request
- accel_rd_valid  out  NUM_ACCEL  one-hot read return
- accel_rd_data  out  LINE_W  shared read line
- mem_addr / mem_wrt_data / mem_wrt_en  out  ADDR_W / WORD_W / 1  drive to memory
- mem_rd_data  in  LINE_W  memory read line, valid the cycle after the address

## Operation
- Exactly one winner or none per cycle. mem_wrt_en = winner's write flag; it is 0 when there is no winner.
- State bits: starve_cnt (0..STARVE_LIMIT), rr_ptr (0..NUM_ACCEL-1), resp register {valid, owner}.
- Winner selection:
  - if cpu_req and (starve_cnt < STARVE_LIMIT or no accel_req): CPU wins.
  - else if any accel_req: round-robin pick. Search starts at rr_ptr, ascending, wrapping at NUM_ACCEL.
- starve_cnt:
  - +1 when the CPU wins while any accel_req is high.
  - cleared when an accelerator is granted, or when no accel_req is high.
  - saturates at STARVE_LIMIT.
- rr_ptr ← (granted index + 1) mod NUM_ACCEL on an accelerator grant; otherwise held.
- Handshake: an accelerator holds req, addr, data and wrt_en stable until it sees accel_gnt. The request completes in the grant cycle. Deasserting req before grant is legal and withdraws the request.
- A granted read loads resp ← {1, owner}. A write or idle cycle loads resp.valid ← 0.
- With resp.valid set, the owner's rd_valid is asserted and mem_rd_data is routed to it.
- Writes produce no return.
- accel_rd_data carries mem_rd_data unconditionally; only the rd_valid strobes qualify it.

## Timing
- Grant, cpu_stall and mem_* are combinational from inputs and state (zero-cycle arbitration).
- Read latency is 1 cycle: read granted at t → rd_valid at t+1 for exactly one cycle.
- Back-to-back reads from any mix of requesters are allowed at one per cycle. Returns arrive in issue order.
- Reset values:
  - state: starve_cnt = 0, rr_ptr = 0, resp.valid = 0.
  - outputs: cpu_rd_valid = 0 and accel_rd_valid = 0. cpu_stall, accel_gnt and mem_wrt_en are 0 whenever no request is present.
- Reset asserted mid-operation drops any in-flight read return; no rd_valid is produced for it.
- Boundary cases:
  - starve_cnt = STARVE_LIMIT with cpu_req high and an accel pending: the accelerator wins, cpu_stall = 1, and the counter clears.
  - NUM_ACCEL = 1: rr_ptr stays 0.

## Structure
- Package datamem_arb_pkg holds:
  - owner_e: OWN_CPU, OWN_ACCEL.
  - resp_t: struct {valid, owner_e kind, accel index}.
  - default width constants.
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr; outputs one-hot gnt and index. It is purely combinational; the pointer register lives in the parent.

## Test plan
- CPU read @0x0040 only → mem_addr = 0x0040 in the same cycle; cpu_rd_valid = 1 next cycle; cpu_rd_data = mem_rd_data[31:0].
- accel0 and accel1 both request continuously, CPU idle, rr_ptr = 0 → grants alternate 0, 1, 0, 1; each grant lasts one cycle.
- CPU reads every cycle while accel1 requests, STARVE_LIMIT = 8 → 8 CPU grants, then accel1 granted with cpu_stall = 1 for that cycle, then the CPU resumes.
- CPU write of 0xDEADBEEF @0x0010 → mem_wrt_en = 1 with that address and data; no rd_valid the next cycle.
- Interleaved reads: CPU @t, accel1 @t+1 → cpu_rd_valid @t+1, accel_rd_valid = 2'b10 @t+2.
- Read granted, then rst pulsed before the next edge → no rd_valid; rr_ptr = 0 and starve_cnt = 0 afterwards.
